ca_row_renderer: RTL

Cellular-automaton pixel stage that sits directly downstream of the VGA sync/counter generator. It consumes the pixel counters, display-enable and sync signals, keeps an 80-cell one-dimensional automaton row, and evolves it by an 8-bit Wolfram rule once per 8-line cell row. It drives registered RGB and re-timed sync outputs to the VGA pins. Each cell is 8×8 pixels, giving 80×60 cells over the 640×480 visible area. With scrolling enabled the top row advances one generation per frame.

---
 rtl/ca_row_renderer_if.sv | 32 +++
 rtl/ca_row_renderer.sv | 110 +++++++++++
 2 files changed

// File: rtl/ca_row_renderer_if.sv
// Pixel-stream bundle between the VGA counter generator (master) and the
// cellular-automaton renderer (slave), plus the renderer's controls and pin outputs.
interface ca_row_renderer_if;
  logic [9:0]  CounterX;
  logic [8:0]  CounterY;
  logic        inDisplayArea;
  logic        h_sync_in;
  logic        v_sync_in;
  logic [7:0]  rule;
  logic        scroll_en;
  logic        restart;
  logic        vga_r;
  logic        vga_g;
  logic        vga_b;
  logic        vga_h_sync;
  logic        vga_v_sync;
  logic [15:0] generation;

  // No valid/ready: the stream advances every pixel clock. Each output is
  // registered, so it reflects the counter/sync values of the previous edge.
  modport master (
    output CounterX, CounterY, inDisplayArea, h_sync_in, v_sync_in,
    output rule, scroll_en, restart,
    input  vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, generation
  );

  modport slave (
    input  CounterX, CounterY, inDisplayArea, h_sync_in, v_sync_in,
    input  rule, scroll_en, restart,
    output vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, generation
  );
endinterface

// File: rtl/ca_row_renderer.sv
// 80-cell 1-D cellular automaton drawn as 8x8-pixel cells, one generation per
// cell row; the top row optionally advances one generation per frame.
module ca_row_renderer #(
  parameter int          SEED_CELL = 40,
  parameter logic [2:0]  ALIVE_RGB = 3'b111,
  parameter logic [2:0]  DEAD_RGB  = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  ca_row_renderer_if.slave  bus
);
  localparam logic [79:0] SEED = 80'd1 << SEED_CELL;

  logic [79:0] top_row;
  logic [79:0] row;
  logic [79:0] next_row;
  logic [7:0]  rule_q;
  logic        restart_pending;
  logic [15:0] generation;
  logic [2:0]  pix;
  logic        h_sync_q;
  logic        v_sync_q;

  logic        line_end;
  logic        frame_end;
  logic        cell_boundary;
  logic        scroll_step;
  logic        do_seed;
  logic [6:0]  cell_idx;
  logic        cell_on;

  // Neighbours wrap modulo 80: rotate the row once each way.
  function automatic logic [79:0] next_gen(input logic [79:0] r, input logic [7:0] rl);
    logic [79:0] left_nb;
    logic [79:0] right_nb;
    logic [79:0] n;
    left_nb  = {r[78:0], r[79]};
    right_nb = {r[0], r[79:1]};
    n = '0;
    for (int i = 0; i < 80; i++) begin
      n[i] = rl[{left_nb[i], r[i], right_nb[i]}];
    end
    return n;
  endfunction

  always_comb begin
    line_end      = (bus.CounterX == 10'd767);
    frame_end     = line_end && (bus.CounterY == 9'd511);
    cell_boundary = line_end && (bus.CounterY[2:0] == 3'd7) && (bus.CounterY < 9'd479);
    scroll_step   = cell_boundary && (bus.CounterY == 9'd7) && bus.scroll_en;
    do_seed       = frame_end && (bus.restart || restart_pending);
    next_row      = next_gen(row, rule_q);
  end

  always_comb begin
    cell_idx = bus.CounterX[9:3];
    cell_on  = (cell_idx < 7'd80) ? row[cell_idx] : 1'b0;
  end

  // Frame end outranks the cell-row boundary; they can never coincide anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_row         <= SEED;
      row             <= SEED;
      rule_q          <= 8'd30;
      restart_pending <= 1'b0;
      generation      <= 16'd0;
    end else if (frame_end) begin
      rule_q <= bus.rule;
      if (do_seed) begin
        top_row         <= SEED;
        row             <= SEED;
        generation      <= 16'd0;
        restart_pending <= 1'b0;
      end else begin
        row <= top_row;
      end
    end else begin
      if (bus.restart) begin
        restart_pending <= 1'b1;
      end
      if (cell_boundary) begin
        row <= next_row;
        if (scroll_step) begin
          top_row    <= next_row;
          generation <= generation + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix      <= 3'b000;
      h_sync_q <= 1'b1;
      v_sync_q <= 1'b1;
    end else begin
      pix      <= bus.inDisplayArea ? (cell_on ? ALIVE_RGB : DEAD_RGB) : 3'b000;
      h_sync_q <= bus.h_sync_in;
      v_sync_q <= bus.v_sync_in;
    end
  end

  assign bus.vga_r      = pix[2];
  assign bus.vga_g      = pix[1];
  assign bus.vga_b      = pix[0];
  assign bus.vga_h_sync = h_sync_q;
  assign bus.vga_v_sync = v_sync_q;
  assign bus.generation = generation;
endmodule
